// File: rtl/dmem_resp.sv
// Load/store responder for the memory-access stage: one request at a time, optional
// wait states, RV32I sub-word extension and byte-lane stores into a word-organised RAM.
module dmem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rena_i,
    input  logic        req_wena_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_reg_addr_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic        resp_rena_o,
    output logic [31:0] resp_rdata_o,
    output logic [4:0]  resp_reg_addr_o,
    output logic        resp_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic           rena_q;
    logic           wena_q;
    logic [2:0]     f3_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic           resp_valid_q;
    logic           resp_rena_q;
    logic [31:0]    resp_rdata_q;
    logic [4:0]     resp_reg_q;
    logic           resp_err_q;

    logic [31:0]    mem_q [DEPTH_WORDS];

    logic           req_err;
    logic           ld_ill;
    logic           st_ill;
    logic           misal;
    logic [3:0]     be;
    logic [31:0]    wdata_al;
    logic [AW-1:0]  idx;
    logic           addr_unused;

    // Upper address bits are intentionally dropped so accesses wrap modulo the RAM size.
    assign addr_unused = ^req_addr_i[31:AW+2];
    assign idx         = addr_q[AW+1:2];

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = 16'(w >> {off[1], 4'b0000});
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    always_comb begin
        ld_ill  = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                  (req_funct3_i == 3'b111);
        st_ill  = req_funct3_i[2] || (req_funct3_i[1:0] == 2'b11);
        misal   = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                  ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        req_err = (req_rena_i && req_wena_i) ||
                  (req_rena_i && (ld_ill || misal)) ||
                  (req_wena_i && (st_ill || misal));
    end

    // Only legal stores reach ACCESS, so the default lane pattern is the full word.
    always_comb begin
        be       = 4'b1111;
        wdata_al = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be       = 4'b0001 << addr_q[1:0];
                wdata_al = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && wena_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wdata_al[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            rena_q       <= 1'b0;
            wena_q       <= 1'b0;
            f3_q         <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rena_q  <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_reg_q   <= 5'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        rena_q       <= req_rena_i;
                        wena_q       <= req_wena_i;
                        f3_q         <= req_funct3_i;
                        addr_q       <= req_addr_i[AW+1:0];
                        wdata_q      <= req_wdata_i;
                        resp_rena_q  <= req_rena_i;
                        resp_reg_q   <= req_reg_addr_i;
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= req_err;
                        if (req_err || !(req_rena_i || req_wena_i)) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                        end else if (WAIT_CYCLES > 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end else begin
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= S_ACCESS;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                S_ACCESS: begin
                    resp_rdata_q <= rena_q ? load_ext(mem_q[idx], f3_q, addr_q[1:0]) : 32'd0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o     = (state_q == S_IDLE) && !arst;
    assign resp_valid_o    = resp_valid_q;
    assign resp_rena_o     = resp_rena_q;
    assign resp_rdata_o    = resp_rdata_q;
    assign resp_reg_addr_o = resp_reg_q;
    assign resp_err_o      = resp_err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: each request pushes its expected response, which is
// popped and compared when the responder presents it.
module tb_dmem_resp;

    localparam int W = 1;

    logic        clk;
    logic        arst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_rena_i;
    logic        req_wena_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_reg_addr_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic        resp_rena_o;
    logic [31:0] resp_rdata_o;
    logic [4:0]  resp_reg_addr_o;
    logic        resp_err_o;

    typedef struct packed {
        logic        rena;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) u_dut (
        .clk            (clk),
        .arst           (arst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_rena_i     (req_rena_i),
        .req_wena_i     (req_wena_i),
        .req_funct3_i   (req_funct3_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_reg_addr_i (req_reg_addr_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_rena_o    (resp_rena_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_reg_addr_o(resp_reg_addr_o),
        .resp_err_o     (resp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, scramble the request bus after the accept edge, optionally stall
    // the response for `stall` cycles, then pop the scoreboard against what appears.
    task automatic txn(input logic rena, input logic wena, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                       input int stall);
        exp_t e;
        exp_t got;
        exp_t snap;
        int   lat;
        sb_q.push_back({rena, exp_data, rd, exp_err});
        @(negedge clk);
        vectors++;
        if (req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_idle: got %b want 1", req_ready_o);
        end
        req_valid_i    = 1'b1;
        req_rena_i     = rena;
        req_wena_i     = wena;
        req_funct3_i   = f3;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_reg_addr_i = rd;
        resp_ready_i   = (stall == 0);
        @(negedge clk);
        req_valid_i    = 1'b0;
        req_rena_i     = 1'($urandom);
        req_wena_i     = 1'($urandom);
        req_funct3_i   = 3'($urandom);
        req_addr_i     = $urandom;
        req_wdata_i    = $urandom;
        req_reg_addr_i = 5'($urandom);
        lat = 1;
        while (resp_valid_o !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat != exp_lat) begin
            miscompares++;
            $display("FAIL latency addr=%h: got %0d cycles want %0d", addr, lat, exp_lat);
        end
        if (stall > 0) begin
            snap = {resp_rena_o, resp_rdata_o, resp_reg_addr_o, resp_err_o};
            req_valid_i = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                vectors++;
                if ({resp_valid_o, resp_rena_o, resp_rdata_o, resp_reg_addr_o, resp_err_o,
                     req_ready_o} !== {1'b1, snap, 1'b0}) begin
                    miscompares++;
                    $display("FAIL stall_hold cycle %0d: valid=%b data=%h ready=%b want valid=1 data=%h ready=0",
                             i, resp_valid_o, resp_rdata_o, req_ready_o, snap.rdata);
                end
            end
            req_valid_i  = 1'b0;
            resp_ready_i = 1'b1;
        end
        e   = sb_q.pop_front();
        got = {resp_rena_o, resp_rdata_o, resp_reg_addr_o, resp_err_o};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL resp addr=%h: got rena=%b data=%h rd=%0d err=%b want rena=%b data=%h rd=%0d err=%b",
                     addr, got.rena, got.rdata, got.rd, got.err, e.rena, e.rdata, e.rd, e.err);
        end
    endtask

    task automatic test_reset;
        arst = 1'b1;
        req_valid_i = 1'b0; req_rena_i = 1'b0; req_wena_i = 1'b0; req_funct3_i = 3'd0;
        req_addr_i = 32'd0; req_wdata_i = 32'd0; req_reg_addr_i = 5'd0; resp_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({req_ready_o, resp_valid_o, resp_rena_o, resp_rdata_o, resp_reg_addr_o, resp_err_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b valid=%b data=%h want all 0",
                     req_ready_o, resp_valid_o, resp_rdata_o);
        end
        arst = 1'b0;
        #1;
        vectors++;
        if ({req_ready_o, resp_valid_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b valid=%b want ready=1 valid=0",
                     req_ready_o, resp_valid_o);
        end
    endtask

    task automatic test_word;
        txn(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, W + 2, 0);
        txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 1'b0, W + 2, 0);
    endtask

    task automatic test_extension;
        txn(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 5'd1, 32'hFFFFFFDE, 1'b0, W + 2, 0);
        txn(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 5'd2, 32'h000000DE, 1'b0, W + 2, 0);
        txn(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 5'd3, 32'hFFFFBEEF, 1'b0, W + 2, 0);
        txn(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 5'd4, 32'h0000DEAD, 1'b0, W + 2, 0);
        txn(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 5'd6, 32'hFFFFFFEF, 1'b0, W + 2, 0);
        txn(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, 5'd7, 32'h000000BE, 1'b0, W + 2, 0);
    endtask

    task automatic test_partial;
        txn(1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 5'd0, 32'h0, 1'b0, W + 2, 0);
        txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd8, 32'hDEAD55EF, 1'b0, W + 2, 0);
        txn(1'b0, 1'b1, 3'b001, 32'h12, 32'hABCD1234, 5'd0, 32'h0, 1'b0, W + 2, 0);
        txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd9, 32'h123455EF, 1'b0, W + 2, 0);
    endtask

    task automatic test_errors;
        txn(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 5'd10, 32'h0, 1'b1, 1, 0);
        txn(1'b0, 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 1, 0);
        txn(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 5'd11, 32'h0, 1'b1, 1, 0);
        txn(1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 1, 0);
        txn(1'b1, 1'b1, 3'b010, 32'h10, 32'h00000000, 5'd12, 32'h0, 1'b1, 1, 0);
        txn(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 5'd13, 32'h0, 1'b0, 1, 0);
        txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd14, 32'h123455EF, 1'b0, W + 2, 0);
    endtask

    task automatic test_backpressure;
        txn(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 5'd15, 32'h00001234, 1'b0, W + 2, 5);
        txn(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 5'd16, 32'h0, 1'b1, 1, 3);
    endtask

    task automatic test_wrap;
        txn(1'b0, 1'b1, 3'b010, 32'h1000, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0, W + 2, 0);
        txn(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 5'd17, 32'hA5A5A5A5, 1'b0, W + 2, 0);
    endtask

    task automatic test_reset_midop;
        txn(1'b0, 1'b1, 3'b010, 32'h20, 32'h0BADF00D, 5'd0, 32'h0, 1'b0, W + 2, 0);
        @(negedge clk);
        req_valid_i = 1'b1; req_rena_i = 1'b0; req_wena_i = 1'b1; req_funct3_i = 3'b010;
        req_addr_i = 32'h20; req_wdata_i = 32'h00000001; req_reg_addr_i = 5'd0;
        resp_ready_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        #1 arst = 1'b1;
        #1;
        vectors++;
        if ({req_ready_o, resp_valid_o, resp_rena_o, resp_rdata_o, resp_reg_addr_o, resp_err_o} !== '0) begin
            miscompares++;
            $display("FAIL midop_reset_outputs: ready=%b valid=%b data=%h want all 0",
                     req_ready_o, resp_valid_o, resp_rdata_o);
        end
        @(negedge clk);
        #1 arst = 1'b0;
        #1;
        vectors++;
        if ({req_ready_o, resp_valid_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL midop_release: ready=%b valid=%b want ready=1 valid=0",
                     req_ready_o, resp_valid_o);
        end
        txn(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd18, 32'h0BADF00D, 1'b0, W + 2, 0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_extension();
        test_partial();
        test_errors();
        test_backpressure();
        test_wrap();
        test_reset_midop();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the pipeline's load/store path. It accepts one access request at a time from the memory-access stage and performs the RV32I load or store against an internal word-organised RAM. Loads return sign- or zero-extended data toward the writeback stage over a valid/ready response channel; stores are acknowledged over the same channel. A configurable wait-state counter models slow memory, so the pipeline must tolerate variable latency.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, 1: wait states inserted before the array access; range 0..15.
- `clk` in 1: single clock, rising edge.
- `arst` in 1: asynchronous, active-high reset.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: responder can accept a request.
- `req_rena_i` in 1: load request.
- `req_wena_i` in 1: store request.
- `req_funct3_i` in 3: access size/sign, RV32I funct3 encoding.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, right-aligned.
- `req_reg_addr_i` in 5: load destination register.
- `resp_valid_o` out 1: response present.
- `resp_ready_i` in 1: writeback side accepts the response.
- `resp_rena_o` out 1: the response is for a load; writeback writes `resp_rdata_o` to `resp_reg_addr_o`.
- `resp_rdata_o` out 32: extended load data; 0 for stores and errors.
- `resp_reg_addr_o` out 5: captured `req_reg_addr_i`.
- `resp_err_o` out 1: misaligned access, illegal funct3, or both enables set.

## Operation
- **FSM states:** IDLE, WAIT, ACCESS, RESP.
- **IDLE:** `req_ready_o`=1. When `req_valid_i`=1, capture all `req_*` fields and select the next state:
  - error → RESP;
  - neither enable set → RESP as a no-op (`resp_err_o`=0);
  - otherwise → WAIT if `WAIT_CYCLES`>0, else ACCESS.
- **WAIT:** 4-bit counter loads `WAIT_CYCLES`-1 on entry and decrements each cycle. When it reaches 0, go to ACCESS.
- **ACCESS:** one cycle, then RESP.
  - Store: the array word is updated at the end of this cycle, byte lanes only.
  - Load: the word is read, and the extended data is registered into `resp_rdata_o`.
- **RESP:** `resp_valid_o`=1. All `resp_*` outputs stay stable until `resp_ready_i`=1, then go to IDLE. `req_ready_o`=0 in every state except IDLE.
- **Word index:** `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- **Loads:**
  - LB 000: sign-extend byte `addr[1:0]`.
  - LH 001: sign-extend half `addr[1]`.
  - LW 010: full word.
  - LBU 100: zero-extend byte `addr[1:0]`.
  - LHU 101: zero-extend half `addr[1]`.
  - 011, 110, 111 → error.
- **Stores:**
  - SB 000: byte enable `1 << addr[1:0]`, data `wdata[7:0]` replicated.
  - SH 001: enables `4'b0011` or `4'b1100`.
  - SW 010: `4'b1111`.
  - Other funct3 → error.
- **Misalignment:** half-word access with `addr[0]`=1, or word access with `addr[1:0]`≠0 → error.
- **Error responses:** no array write, `resp_rdata_o`=0, `resp_err_o`=1. `resp_rena_o` reflects the captured `req_rena_i`, and writeback must suppress the register write on error.
- **Both enables set:** error; the store is not performed.
- **RAM contents:** not cleared by reset; undefined until written.

## Timing
- **Reset values:** state=IDLE, counter=0, `req_ready_o`=1 after reset deasserts (0 while `arst`=1). All resp outputs are 0.
- **Latency**, from the accept edge to the first cycle with `resp_valid_o`=1:
  - valid access: `WAIT_CYCLES`+2 cycles;
  - error or no-op: 1 cycle.
- **Throughput:** one request per `WAIT_CYCLES`+3 cycles, assuming `resp_ready_i` is held at 1. IDLE costs one cycle between transactions.
- **Reset mid-operation:** `arst` during WAIT or RESP returns the FSM to IDLE immediately and discards the transaction. `arst` asserted before the ACCESS clock edge suppresses the store write.
- **Stalled response:** `resp_ready_i` held low keeps RESP indefinitely. New requests are not accepted and `req_*` inputs are ignored.
- `req_*` inputs are sampled only on the accept edge, so later changes have no effect.

## Test plan
- **Store/load word:** `WAIT_CYCLES`=1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 reg 5 → `resp_rdata_o`=0xDEADBEEF, `resp_reg_addr_o`=5, `resp_valid_o` 3 cycles after accept, `resp_err_o`=0.
- **Byte/half extension:** after the word above:
  - LB 0x13 → 0xFFFFFFDE;
  - LBU 0x13 → 0x000000DE;
  - LH 0x10 → 0xFFFFBEEF;
  - LHU 0x12 → 0x0000DEAD.
- **Partial stores:** SB 0x11 data 0x55 then LW 0x10 → 0xDEAD55EF. SH 0x12 data 0x1234 then LW 0x10 → 0x123455EF.
- **Errors:**
  - LW 0x12 → `resp_err_o`=1 and `resp_rdata_o`=0, 1 cycle after accept.
  - SH 0x11 → `resp_err_o`=1, and a following LW 0x10 still returns 0x123455EF.
  - funct3 011 load → `resp_err_o`=1.
- **Backpressure and wrap:**
  - `resp_ready_i`=0 for 5 cycles → response held stable and `req_ready_o`=0 throughout.
  - With `DEPTH_WORDS`=1024, SW 0x1000 data 0xA5A5A5A5, then LW 0x0 → 0xA5A5A5A5.
- **Reset mid-op:** `WAIT_CYCLES`=3. Assert `arst` during WAIT of SW 0x20 data 0x1, then after release LW 0x20 → the old value is unchanged. All outputs read 0 and `req_ready_o`=0 while `arst`=1.
